// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the external async SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 19;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned WCNT_W         = 4;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter; remembers the last winner so contended grants alternate.
module rr_arb2
  import sram_arb_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  // One-hot grant: a lone requester wins; contention goes to the port that did not win last
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (ROUND_ROBIN != 0 && last_grant == PORT0) grant = 2'b10;
        else                                         grant = 2'b01;
      end
      default: grant = 2'b00;
    endcase
  end

  // Track the last winner; starts at port 1 so port 0 takes the first contended grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 last_grant <= PORT1;
    else if (update && |req)   last_grant <= grant[1];
  end

endmodule

// File: rtl/sram_arbiter.sv
// Sequences the external 8-bit async SRAM and shares it between the 6502 core (port 0)
// and an auxiliary master (port 1). Strobes are decoded from the FSM state so an
// asynchronous reset releases the bus in the same cycle.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_oe,
  output logic              busy
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_arbiter: WAIT_CYCLES must be in 1..15");
  end

  state_t              state, state_nx;
  logic [1:0]          grant;
  logic                start;
  logic                gnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [WCNT_W-1:0]   wcnt;
  logic                last_beat;

  rr_arb2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({p1_req, p0_req}),
    .update (state == IDLE),
    .grant  (grant)
  );

  assign start     = (state == IDLE) && (grant != 2'b00);
  assign last_beat = (state == ACCESS) && (wcnt == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> DONE -> IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (wcnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Transaction latch and wait-state counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q   <= PORT0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wcnt    <= '0;
    end else begin
      if (start) begin
        gnt_q   <= grant[1];
        we_q    <= grant[1] ? p1_we    : p0_we;
        addr_q  <= grant[1] ? p1_addr  : p0_addr;
        wdata_q <= grant[1] ? p1_wdata : p0_wdata;
      end
      if (state == SETUP)
        wcnt <= WCNT_W'(WAIT_CYCLES - 1);
      else if (state == ACCESS && wcnt != '0)
        wcnt <= wcnt - WCNT_W'(1);
    end
  end

  // Read capture on the final strobe edge, into the granted port only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else if (last_beat && !we_q) begin
      if (gnt_q == PORT1) p1_rdata <= sram_din;
      else                p0_rdata <= sram_din;
    end
  end

  // Strobe and handshake decode; sram_oe and sram_oe_n are never both active
  always_comb begin
    sram_ce_n = 1'b1;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_oe   = 1'b0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    case (state)
      SETUP: begin
        sram_ce_n = 1'b0;
        sram_oe   = we_q;
        sram_oe_n = we_q;
      end
      ACCESS: begin
        sram_ce_n = 1'b0;
        sram_oe   = we_q;
        sram_we_n = !we_q;
        sram_oe_n = we_q;
      end
      DONE: begin
        sram_ce_n = 1'b0;
        sram_oe   = we_q;
        p0_ack    = (gnt_q == PORT0);
        p1_ack    = (gnt_q == PORT1);
      end
      default: ;
    endcase
  end

  assign sram_addr = addr_q;
  assign sram_dout = wdata_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: four instances (W=2 RR, W=2 fixed priority,
// W=1 RR, W=3 RR) sharing one clock and reset, each with its own SRAM model.
module tb_sram_arbiter;

  localparam int NI = 4;

  logic        clk;
  logic        reset;

  logic        p0_req   [NI];
  logic        p1_req   [NI];
  logic        p0_we    [NI];
  logic        p1_we    [NI];
  logic [18:0] p0_addr  [NI];
  logic [18:0] p1_addr  [NI];
  logic [7:0]  p0_wdata [NI];
  logic [7:0]  p1_wdata [NI];
  logic        p0_ack   [NI];
  logic        p1_ack   [NI];
  logic [7:0]  p0_rdata [NI];
  logic [7:0]  p1_rdata [NI];
  logic [18:0] sram_addr[NI];
  logic        sram_ce_n[NI];
  logic        sram_we_n[NI];
  logic        sram_oe_n[NI];
  logic [7:0]  sram_dout[NI];
  logic [7:0]  sram_din [NI];
  logic        sram_oe  [NI];
  logic        busy     [NI];

  logic [7:0]  mem [NI][524288];

  int total;
  int bad;

  logic [7:0] ref_mem [NI][16];
  bit         ref_vld [NI][16];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned WC = (g == 2) ? 1 : (g == 3) ? 3 : 2;
    localparam int unsigned RR = (g == 1) ? 0 : 1;
    sram_arbiter #(
      .ADDR_W      (19),
      .WAIT_CYCLES (WC),
      .ROUND_ROBIN (RR)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .p0_req    (p0_req[g]),
      .p1_req    (p1_req[g]),
      .p0_we     (p0_we[g]),
      .p1_we     (p1_we[g]),
      .p0_addr   (p0_addr[g]),
      .p1_addr   (p1_addr[g]),
      .p0_wdata  (p0_wdata[g]),
      .p1_wdata  (p1_wdata[g]),
      .p0_ack    (p0_ack[g]),
      .p1_ack    (p1_ack[g]),
      .p0_rdata  (p0_rdata[g]),
      .p1_rdata  (p1_rdata[g]),
      .sram_addr (sram_addr[g]),
      .sram_ce_n (sram_ce_n[g]),
      .sram_we_n (sram_we_n[g]),
      .sram_oe_n (sram_oe_n[g]),
      .sram_dout (sram_dout[g]),
      .sram_din  (sram_din[g]),
      .sram_oe   (sram_oe[g]),
      .busy      (busy[g])
    );
    assign sram_din[g] = mem[g][sram_addr[g]];
  end

  // SRAM models: a byte is stored whenever chip select and write strobe are both low
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++)
      if (!sram_ce_n[k] && !sram_we_n[k]) mem[k][sram_addr[k]] <= sram_dout[k];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int k, input int port, input logic r, input logic we,
                         input logic [18:0] a, input logic [7:0] d);
    if (port == 0) begin
      p0_req[k] = r; p0_we[k] = we; p0_addr[k] = a; p0_wdata[k] = d;
    end else begin
      p1_req[k] = r; p1_we[k] = we; p1_addr[k] = a; p1_wdata[k] = d;
    end
  endtask

  // Bus-level invariants on every instance, every cycle
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (!sram_we_n[k]) chk($sformatf("inv%0d_we_oe", k), {30'd0, sram_oe[k], sram_oe_n[k]}, 32'd3);
        if (!sram_oe_n[k]) chk($sformatf("inv%0d_oen_oe", k), {31'd0, sram_oe[k]}, 32'd0);
        chk($sformatf("inv%0d_two_acks", k), {31'd0, p0_ack[k] & p1_ack[k]}, 32'd0);
      end
    end
  end

  // One isolated access; cycle 0 is the first IDLE cycle with req high
  task automatic single(input int k, input int port, input logic we, input logic [18:0] a,
                        input logic [7:0] d, output int ack_cyc, output int we_lo,
                        output int oen_lo, output int oe_hi, output int ce_lo);
    ack_cyc = -1; we_lo = 0; oen_lo = 0; oe_hi = 0; ce_lo = 0;
    @(posedge clk); #1;
    set_req(k, port, 1'b1, we, a, d);
    for (int cyc = 0; cyc < 20 && ack_cyc < 0; cyc++) begin
      @(negedge clk);
      if (!sram_we_n[k]) we_lo++;
      if (!sram_oe_n[k]) oen_lo++;
      if (sram_oe[k])    oe_hi++;
      if (!sram_ce_n[k]) ce_lo++;
      if ((port == 0) ? p0_ack[k] : p1_ack[k]) ack_cyc = cyc;
    end
    @(posedge clk); #1;
    set_req(k, port, 1'b0, 1'b0, '0, '0);
  endtask

  // Both ports hold req high through four completions; check winner order and spacing
  task automatic contend(input int k, input logic [3:0] exp_seq);
    int n, last, cyc;
    logic [3:0] seq;
    n = 0; last = -1; seq = '0;
    @(posedge clk); #1;
    set_req(k, 0, 1'b1, 1'b1, 19'h00100, 8'h11);
    set_req(k, 1, 1'b1, 1'b1, 19'h00200, 8'h22);
    for (cyc = 0; cyc < 60 && n < 4; cyc++) begin
      @(negedge clk);
      if (p0_ack[k] || p1_ack[k]) begin
        seq[n] = p1_ack[k];
        if (n == 0) chk($sformatf("contend%0d_first_ack", k), cyc, 4);
        else        chk($sformatf("contend%0d_ack_gap", k), cyc - last, 5);
        last = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    set_req(k, 0, 1'b0, 1'b0, '0, '0);
    set_req(k, 1, 1'b0, 1'b0, '0, '0);
    chk($sformatf("contend%0d_acks", k), n, 4);
    chk($sformatf("contend%0d_order", k), {28'd0, seq}, {28'd0, exp_seq});
  endtask

  // Random requester checked against a per-address last-written scoreboard
  task automatic rand_port(input int k, input int port, input int n);
    logic [3:0]  idx;
    logic        we;
    logic [7:0]  wd;
    logic [18:0] a;
    logic [7:0]  rd;
    int          gap;
    bit          got;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      if (gap != 0) begin
        set_req(k, port, 1'b0, 1'b0, '0, '0);
        repeat (gap) begin @(posedge clk); #1; end
      end
      idx = 4'($urandom_range(0, 15));
      we  = 1'($urandom_range(0, 1));
      wd  = 8'($urandom);
      a   = {idx, 15'(int'(idx) * 1237)};
      set_req(k, port, 1'b1, we, a, wd);
      got = 1'b0;
      for (int cyc = 0; cyc < 64 && !got; cyc++) begin
        @(negedge clk);
        got = (port == 0) ? p0_ack[k] : p1_ack[k];
      end
      if (!got) begin
        chk($sformatf("rand%0d_p%0d_ack_timeout", k, port), 0, 1);
        set_req(k, port, 1'b0, 1'b0, '0, '0);
        return;
      end
      if (we) begin
        ref_mem[k][idx] = wd;
        ref_vld[k][idx] = 1'b1;
      end else if (ref_vld[k][idx]) begin
        rd = (port == 0) ? p0_rdata[k] : p1_rdata[k];
        chk($sformatf("rand%0d_p%0d_rdata", k, port), {24'd0, rd}, {24'd0, ref_mem[k][idx]});
      end
      @(posedge clk); #1;
    end
    set_req(k, 0 + port, 1'b0, 1'b0, '0, '0);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [18:0] addr;
    logic [7:0]  wd;
    int          exp_ack;
    int          exp_we_lo;
    int          exp_oen_lo;
    int          exp_oe_hi;
    logic [7:0]  exp_r0;
    logic [7:0]  exp_r1;
    logic [7:0]  exp_mem;
  } vec_t;

  initial begin
    vec_t vt [7];
    int   ack_cyc, we_lo, oen_lo, oe_hi, ce_lo;
    int   n_ack, last_ack, ce_hi, gap_we;
    int   ack_seen, busy_seen;

    // Directed single accesses on the WAIT_CYCLES=2 instance
    vt[0] = '{0, 1'b1, 19'h01234, 8'hA5, 4, 2, 0, 4, 8'h00, 8'h00, 8'hA5};
    vt[1] = '{0, 1'b1, 19'h7FFFF, 8'h3C, 4, 2, 0, 4, 8'h00, 8'h00, 8'h3C};
    vt[2] = '{1, 1'b0, 19'h7FFFF, 8'h00, 4, 0, 3, 0, 8'h00, 8'h3C, 8'h3C};
    vt[3] = '{0, 1'b0, 19'h01234, 8'h00, 4, 0, 3, 0, 8'hA5, 8'h3C, 8'hA5};
    vt[4] = '{1, 1'b1, 19'h00000, 8'h5A, 4, 2, 0, 4, 8'hA5, 8'h3C, 8'h5A};
    vt[5] = '{1, 1'b0, 19'h00000, 8'h00, 4, 0, 3, 0, 8'hA5, 8'h5A, 8'h5A};
    vt[6] = '{0, 1'b0, 19'h7FFFF, 8'h00, 4, 0, 3, 0, 8'h3C, 8'h5A, 8'h3C};

    total = 0;
    bad   = 0;
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      set_req(k, 0, 1'b0, 1'b0, '0, '0);
      set_req(k, 1, 1'b0, 1'b0, '0, '0);
      for (int j = 0; j < 16; j++) begin
        ref_mem[k][j] = 8'h00;
        ref_vld[k][j] = 1'b0;
      end
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ce_n",  {31'd0, sram_ce_n[0]}, 32'd1);
    chk("rst_we_n",  {31'd0, sram_we_n[0]}, 32'd1);
    chk("rst_oe_n",  {31'd0, sram_oe_n[0]}, 32'd1);
    chk("rst_oe",    {31'd0, sram_oe[0]},   32'd0);
    chk("rst_addr",  {13'd0, sram_addr[0]}, 32'd0);
    chk("rst_dout",  {24'd0, sram_dout[0]}, 32'd0);
    chk("rst_acks",  {30'd0, p1_ack[0], p0_ack[0]}, 32'd0);
    chk("rst_rdata", {16'd0, p1_rdata[0], p0_rdata[0]}, 32'd0);
    chk("rst_busy",  {31'd0, busy[0]}, 32'd0);
    reset = 1'b0;

    // Contention: alternating winners vs fixed priority
    fork
      contend(0, 4'b1010);
      contend(1, 4'b0000);
    join

    // Table-driven single accesses
    for (int i = 0; i < 7; i++) begin
      single(0, vt[i].port, vt[i].we, vt[i].addr, vt[i].wd, ack_cyc, we_lo, oen_lo, oe_hi, ce_lo);
      chk($sformatf("vec%0d_ack_cycle", i), ack_cyc, vt[i].exp_ack);
      chk($sformatf("vec%0d_we_n_low", i), we_lo, vt[i].exp_we_lo);
      chk($sformatf("vec%0d_oe_n_low", i), oen_lo, vt[i].exp_oen_lo);
      chk($sformatf("vec%0d_oe_high", i), oe_hi, vt[i].exp_oe_hi);
      chk($sformatf("vec%0d_ce_n_low", i), ce_lo, 4);
      chk($sformatf("vec%0d_p0_rdata", i), {24'd0, p0_rdata[0]}, {24'd0, vt[i].exp_r0});
      chk($sformatf("vec%0d_p1_rdata", i), {24'd0, p1_rdata[0]}, {24'd0, vt[i].exp_r1});
      chk($sformatf("vec%0d_mem", i), {24'd0, mem[0][vt[i].addr]}, {24'd0, vt[i].exp_mem});
      @(negedge clk);
      chk($sformatf("vec%0d_idle_bus", i), {29'd0, sram_ce_n[0], sram_oe[0], busy[0]}, 32'd4);
    end

    // Back-to-back writes from port 0: req stays high, fields change after each ack
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 1'b1, 19'h00010, 8'h10);
    n_ack = 0; last_ack = 0; ce_hi = 0; gap_we = 0;
    for (int cyc = 0; cyc < 40 && n_ack < 3; cyc++) begin
      @(negedge clk);
      if (sram_ce_n[0])  ce_hi++;
      if (!sram_we_n[0]) gap_we++;
      if (p0_ack[0]) begin
        if (n_ack > 0) begin
          chk($sformatf("b2b%0d_ack_gap", n_ack), cyc - last_ack, 5);
          chk($sformatf("b2b%0d_ce_n_high", n_ack), ce_hi, 1);
          chk($sformatf("b2b%0d_we_n_low", n_ack), gap_we, 2);
        end
        last_ack = cyc; ce_hi = 0; gap_we = 0;
        n_ack++;
        @(posedge clk); #1;
        if (n_ack < 3) set_req(0, 0, 1'b1, 1'b1, 19'(19'h00010 + n_ack), 8'(8'h10 + n_ack));
        else           set_req(0, 0, 1'b0, 1'b0, '0, '0);
      end
    end
    chk("b2b_acks", n_ack, 3);
    for (int j = 0; j < 3; j++)
      chk($sformatf("b2b_mem%0d", j), {24'd0, mem[0][19'h00010 + 19'(j)]}, 32'h10 + j);

    // Reset in the middle of a write strobe
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 1'b1, 19'h00055, 8'h99);
    repeat (3) @(negedge clk);
    chk("rst_mid_we_active", {31'd0, sram_we_n[0]}, 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_strobes", {28'd0, sram_ce_n[0], sram_we_n[0], sram_oe_n[0], sram_oe[0]}, 32'hE);
    chk("rst_mid_ack", {31'd0, p0_ack[0]}, 32'd0);
    @(posedge clk); #1;
    set_req(0, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b0;
    ack_seen = 0; busy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (p0_ack[0] || p1_ack[0]) ack_seen++;
      if (busy[0]) busy_seen++;
    end
    chk("rst_mid_no_ack", ack_seen, 0);
    chk("rst_mid_busy", busy_seen, 0);

    // Random mixed traffic, WAIT_CYCLES=1 and 3
    fork
      rand_port(2, 0, 2500);
      rand_port(2, 1, 2500);
      rand_port(3, 0, 2500);
      rand_port(3, 1, 2500);
    join

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
